// File: rtl/round_ctrl_pkg.sv
// Package for round_controller: FSM state encoding, default parameter values
// and small elaboration-time helpers.
package round_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_INPUT,
    ST_JUDGE,
    ST_DONE
  } state_e;

  localparam int DEF_N_CH          = 8;
  localparam int DEF_MAX_LEN       = 16;
  localparam int DEF_N_ROUNDS      = 10;
  localparam int DEF_SHOW_TICKS    = 5;
  localparam int DEF_GAP_TICKS     = 2;
  localparam int DEF_TIMEOUT_TICKS = 50;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Address width of at least one bit, so a one-entry buffer still has a port.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pattern_buf.sv
// pattern_buf: storage for the symbols of the current round.
// One synchronous write port, one asynchronous read port.
//   clk          write clock
//   we/waddr/wdata  write port
//   raddr/rdata  combinational read port
// Depth is rounded up to 2**AW so any AW-bit address is in range; only the
// first MAX_LEN entries are ever written by the controller.
module pattern_buf #(
  parameter int W  = 3,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/round_controller.sv
// round_controller: one memory-game round sequencer. Loads a pattern of
// channel symbols, plays it on the LEDs, then checks the player's presses.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   tick            single-cycle pacing strobe for all durations
//   start, len      start a game with pattern length len (1..MAX_LEN)
//   pat_req/ack/sym pattern symbol handshake (one symbol per acked cycle)
//   button          single-cycle press pulses, one bit per channel
//   led             one-hot display / press echo
//   score,round_cnt rounds won / rounds played in the current game
//   round_win/lose  one-cycle verdict pulse per round
//   game_done       held after the last round
//   busy            high whenever a game is in progress
//
// Build option: define ROUND_CTRL_TIMEOUT_EN to lose a round after
// TIMEOUT_TICKS ticks without a press; otherwise input waits forever.
module round_controller
  import round_ctrl_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int MAX_LEN       = DEF_MAX_LEN,
  parameter int N_ROUNDS      = DEF_N_ROUNDS,
  parameter int SHOW_TICKS    = DEF_SHOW_TICKS,
  parameter int GAP_TICKS     = DEF_GAP_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          start,
  input  logic [$clog2(MAX_LEN+1)-1:0]  len,
  output logic                          pat_req,
  input  logic                          pat_ack,
  input  logic [$clog2(N_CH)-1:0]       pat_sym,
  input  logic [N_CH-1:0]               button,
  output logic [N_CH-1:0]               led,
  output logic [$clog2(N_ROUNDS+1)-1:0] score,
  output logic [$clog2(N_ROUNDS+1)-1:0] round_cnt,
  output logic                          round_win,
  output logic                          round_lose,
  output logic                          game_done,
  output logic                          busy
);

  localparam int LW = $clog2(MAX_LEN+1);
  localparam int SW = $clog2(N_CH);
  localparam int RW = $clog2(N_ROUNDS+1);
  localparam int AW = clog2_min1(MAX_LEN);
  localparam int TW = $clog2(max3(SHOW_TICKS, GAP_TICKS, TIMEOUT_TICKS) + 1);

  state_e        state;
  logic [LW-1:0] idx, len_q;
  logic [TW-1:0] tcnt;
  logic          win;

  logic [SW-1:0] sym_mod, rdata;
  logic [AW-1:0] raddr;
  logic          we, idx_last, btn_match;

  function automatic logic [N_CH-1:0] onehot(input logic [SW-1:0] s);
    return {{(N_CH-1){1'b0}}, 1'b1} << s;
  endfunction

  // pat_sym can only exceed N_CH-1 by less than N_CH, so one subtract is a
  // full modulo reduction.
  always_comb begin
    sym_mod = pat_sym;
    if (32'(pat_sym) >= N_CH) sym_mod = pat_sym - SW'(N_CH);
  end

  // Read address looks ahead in SHOW_OFF so the next symbol is ready when
  // the gap ends and can be registered straight onto the LEDs.
  always_comb begin
    raddr = idx[AW-1:0];
    case (state)
      ST_LOAD:     raddr = '0;
      ST_SHOW_OFF: raddr = idx[AW-1:0] + AW'(1);
      default:     raddr = idx[AW-1:0];
    endcase
  end

  assign we        = (state == ST_LOAD) && pat_ack;
  assign idx_last  = (idx == len_q - LW'(1));
  assign btn_match = (button == onehot(rdata));

  pattern_buf #(.W(SW), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (idx[AW-1:0]),
    .wdata (sym_mod),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      len_q      <= '0;
      tcnt       <= '0;
      win        <= 1'b0;
      pat_req    <= 1'b0;
      led        <= '0;
      score      <= '0;
      round_cnt  <= '0;
      round_win  <= 1'b0;
      round_lose <= 1'b0;
      game_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      round_win  <= 1'b0;
      round_lose <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start && len != '0 && 32'(len) <= MAX_LEN) begin
            len_q     <= len;
            score     <= '0;
            round_cnt <= '0;
            idx       <= '0;
            tcnt      <= '0;
            pat_req   <= 1'b1;
            busy      <= 1'b1;
            game_done <= 1'b0;
            led       <= '0;
            state     <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (pat_ack) begin
            if (idx_last) begin
              // Entry 0 may be the symbol being written right now (len==1),
              // so forward it instead of reading the buffer.
              led     <= onehot((idx == '0) ? sym_mod : rdata);
              pat_req <= 1'b0;
              idx     <= '0;
              tcnt    <= '0;
              state   <= ST_SHOW_ON;
            end else begin
              idx <= idx + LW'(1);
            end
          end
        end

        ST_SHOW_ON: begin
          if (tick) begin
            if (tcnt == TW'(SHOW_TICKS-1)) begin
              tcnt  <= '0;
              led   <= '0;
              state <= ST_SHOW_OFF;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end

        ST_SHOW_OFF: begin
          if (tick) begin
            if (tcnt == TW'(GAP_TICKS-1)) begin
              tcnt <= '0;
              if (idx_last) begin
                idx   <= '0;
                state <= ST_INPUT;
              end else begin
                idx   <= idx + LW'(1);
                led   <= onehot(rdata);
                state <= ST_SHOW_ON;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end

        ST_INPUT: begin
          led <= button;
          if (button != '0) begin
            tcnt <= '0;
            if (btn_match) begin
              if (idx_last) begin
                win       <= 1'b1;
                round_win <= 1'b1;
                state     <= ST_JUDGE;
              end else begin
                idx <= idx + LW'(1);
              end
            end else begin
              // Wrong channel or several buttons at once: abort the round.
              win        <= 1'b0;
              round_lose <= 1'b1;
              state      <= ST_JUDGE;
            end
          end
`ifdef ROUND_CTRL_TIMEOUT_EN
          else if (tick) begin
            if (tcnt == TW'(TIMEOUT_TICKS-1)) begin
              win        <= 1'b0;
              round_lose <= 1'b1;
              state      <= ST_JUDGE;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
`endif
        end

        ST_JUDGE: begin
          led       <= '0;
          idx       <= '0;
          tcnt      <= '0;
          round_cnt <= round_cnt + RW'(1);
          score     <= score + RW'(win);
          if (round_cnt == RW'(N_ROUNDS-1)) begin
            busy      <= 1'b0;
            game_done <= 1'b1;
            state     <= ST_DONE;
          end else begin
            pat_req <= 1'b1;
            state   <= ST_LOAD;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with default parameters.
module tb_round_controller;

  logic       clk = 1'b0;
  logic       rst, tick, start, pat_ack;
  logic [4:0] len;
  logic [2:0] pat_sym;
  logic [7:0] button, led;
  logic       pat_req, round_win, round_lose, game_done, busy;
  logic [3:0] score, round_cnt;

  int nvec = 0;
  int nerr = 0;
  int pat[16];
  int plen;

  round_controller dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .len(len),
    .pat_req(pat_req), .pat_ack(pat_ack), .pat_sym(pat_sym),
    .button(button), .led(led), .score(score), .round_cnt(round_cnt),
    .round_win(round_win), .round_lose(round_lose),
    .game_done(game_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tk();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] l);
    start = 1'b1; len = l; cyc(); start = 1'b0;
  endtask

  task automatic load_pat();
    for (int i = 0; i < plen; i++) begin
      if (i == 1) cyc();  // one stalled cycle without ack
      chk("pat_req", 32'(pat_req), 32'd1);
      pat_ack = 1'b1; pat_sym = 3'(pat[i]);
      cyc();
      pat_ack = 1'b0;
    end
    chk("pat_req_drop", 32'(pat_req), 32'd0);
  endtask

  // Plays the show phase: 5 ticks lit, 2 ticks dark per symbol. Stray
  // presses are injected on every tick and must have no effect.
  task automatic show(input logic [7:0] stray);
    logic [31:0] exp;
    for (int i = 0; i < plen; i++) begin
      exp = 32'd1 << pat[i];
      chk("show_on", 32'(led), exp);
      for (int t = 0; t < 5; t++) begin
        button = stray; tk(); button = '0;
        cyc();
        if (t < 4) chk("show_hold", 32'(led), exp);
      end
      chk("show_gap", 32'(led), 32'd0);
      tk(); tk();
    end
    chk("input_led", 32'(led), 32'd0);
    chk("input_busy", 32'(busy), 32'd1);
  endtask

  task automatic press(input logic [7:0] b);
    button = b; cyc(); button = '0;
    chk("echo", 32'(led), 32'(b));
  endtask

  task automatic play_round(input bit w);
    load_pat();
    show(8'h00);
    if (w) begin
      for (int i = 0; i < plen; i++) press(8'(32'd1 << pat[i]));
      chk("fill_win", 32'(round_win), 32'd1);
    end else begin
      press(8'(32'd1 << ((pat[0] + 1) % 8)));
      chk("fill_lose", 32'(round_lose), 32'd1);
    end
    cyc();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; len = '0;
    pat_ack = 1'b0; pat_sym = '0; button = '0;
    cyc(2);
    rst = 1'b0;
    cyc();
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pat_req", 32'(pat_req), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_round_cnt", 32'(round_cnt), 32'd0);
    chk("rst_done", 32'(game_done), 32'd0);

    // Round 1: symbols 2,5,0 played back correctly.
    pat[0] = 2; pat[1] = 5; pat[2] = 0; plen = 3;
    do_start(5'd3);
    chk("start_busy", 32'(busy), 32'd1);
    load_pat();
    show(8'h10);
    press(8'h04);
    chk("r1_no_early_win", 32'(round_win), 32'd0);
    cyc();
    chk("echo_one_cycle", 32'(led), 32'd0);
    press(8'h20);
    press(8'h01);
    chk("r1_win", 32'(round_win), 32'd1);
    chk("r1_no_lose", 32'(round_lose), 32'd0);
    cyc();
    chk("r1_win_pulse_end", 32'(round_win), 32'd0);
    chk("r1_score", 32'(score), 32'd1);
    chk("r1_round_cnt", 32'(round_cnt), 32'd1);
    chk("r1_next_load", 32'(pat_req), 32'd1);

    // Round 2: wrong second press aborts; a start while busy is ignored.
    load_pat();
    do_start(5'd5);
    show(8'h00);
    press(8'h04);
    press(8'h08);
    chk("r2_lose", 32'(round_lose), 32'd1);
    chk("r2_no_win", 32'(round_win), 32'd0);
    cyc();
    chk("r2_score", 32'(score), 32'd1);
    chk("r2_round_cnt", 32'(round_cnt), 32'd2);
    chk("r2_next_load", 32'(pat_req), 32'd1);

    // Round 3: two buttons at once is a mismatch.
    load_pat();
    show(8'h00);
    press(8'h24);
    chk("r3_lose", 32'(round_lose), 32'd1);
    cyc();
    chk("r3_score", 32'(score), 32'd1);
    chk("r3_round_cnt", 32'(round_cnt), 32'd3);

    // Rounds 4..9 won, round 10 lost: 7 wins of 10.
    for (int r = 0; r < 6; r++) play_round(1'b1);
    play_round(1'b0);
    chk("done_flag", 32'(game_done), 32'd1);
    chk("done_score", 32'(score), 32'd7);
    chk("done_round_cnt", 32'(round_cnt), 32'd10);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_led", 32'(led), 32'd0);
    chk("done_pat_req", 32'(pat_req), 32'd0);
    cyc(3);
    do_start(5'd0);
    chk("done_hold", 32'(game_done), 32'd1);
    chk("done_hold_score", 32'(score), 32'd7);

    // New game, length 1.
    pat[0] = 7; plen = 1;
    do_start(5'd1);
    chk("new_score", 32'(score), 32'd0);
    chk("new_round_cnt", 32'(round_cnt), 32'd0);
    chk("new_done", 32'(game_done), 32'd0);
    chk("new_busy", 32'(busy), 32'd1);
    load_pat();
    show(8'h00);
`ifdef ROUND_CTRL_TIMEOUT_EN
    repeat (49) tk();
    chk("to_not_yet", 32'(round_lose), 32'd0);
    chk("to_still_input", 32'(pat_req), 32'd0);
    tk();
    chk("to_lose", 32'(round_lose), 32'd1);
    cyc();
    chk("to_score", 32'(score), 32'd0);
    chk("to_round_cnt", 32'(round_cnt), 32'd1);
`else
    repeat (200) tk();
    chk("wait_no_lose", 32'(round_lose), 32'd0);
    chk("wait_no_load", 32'(pat_req), 32'd0);
    chk("wait_round_cnt", 32'(round_cnt), 32'd0);
    press(8'h80);
    chk("wait_win", 32'(round_win), 32'd1);
    cyc();
    chk("wait_score", 32'(score), 32'd1);
    chk("wait_round_cnt2", 32'(round_cnt), 32'd1);
`endif

    // Reset in SHOW_ON.
    pat[0] = 3; plen = 1;
    load_pat();
    chk("pre_rst_led", 32'(led), 32'h08);
    tk();
    rst = 1'b1;
    cyc();
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_pat_req", 32'(pat_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_win", 32'(round_win), 32'd0);
    chk("mid_rst_lose", 32'(round_lose), 32'd0);
    chk("mid_rst_round_cnt", 32'(round_cnt), 32'd0);
    rst = 1'b0;
    do_start(5'd0);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_pat_req", 32'(pat_req), 32'd0);
    do_start(5'd17);
    chk("len17_busy", 32'(busy), 32'd0);
    do_start(5'd16);
    chk("len16_busy", 32'(busy), 32'd1);
    chk("len16_pat_req", 32'(pat_req), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
